// File: rtl/mem_sync_bw.sv
// mem_sync_bw: 1W/2R byte-enable memory (ra/re->rd/rvalid, wa/wd/we/wbe, dbg_a/dbg_e->dbg_o), registered reads, RDW mode, clear engine (init_busy)
module mem_sync_bw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH = 1024,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic              re,
  output logic [DATA_W-1:0] rd,
  output logic              rvalid,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0] dbg_a,
  input  logic              dbg_e,
  output logic [DATA_W-1:0] dbg_o,
  output logic              init_busy
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic w_ok, r_ok, d_ok;
  logic [DATA_W-1:0] w_new, r_word, d_word;
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] nw, input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = old;
    for (int i = 0; i < NB; i++) if (be[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction
  assign init_busy = state == CLEAR;
  assign w_ok = we && ({1'b0, wa} < DEPTH_W);
  assign r_ok = {1'b0, ra} < DEPTH_W;
  assign d_ok = {1'b0, dbg_a} < DEPTH_W;
  assign w_new = merge(mem[wa], wd, wbe);
  assign r_word = (RDW_MODE == 0 && w_ok && wa == ra) ? w_new : mem[ra];
  assign d_word = (RDW_MODE == 0 && w_ok && wa == dbg_a) ? w_new : mem[dbg_a];
  always_comb begin
    state_n = (state == CLEAR && cnt == LAST) ? READY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == CLEAR) ? cnt + ONE : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      rd <= '0;
      rvalid <= 1'b0;
      dbg_o <= '0;
    end else begin
      rvalid <= re;
      rd <= (re && r_ok) ? r_word : '0;
      dbg_o <= (dbg_e && d_ok) ? d_word : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt[ADDR_W-1:0]] <= '0;
      else if (w_ok) mem[wa] <= w_new;
    end
  end
endmodule

// File: tb/tb_mem_sync_bw.sv
// tb_mem_sync_bw: vector table, directed clear/reset sequences and random traffic vs a word-level model, for write-first/1024 and read-first/1000 instances
module tb_mem_sync_bw;
  logic clk = 0, rst = 1;
  logic [9:0] ra = 0, wa = 0, dbg_a = 0;
  logic re = 0, we = 0, dbg_e = 0;
  logic [31:0] wd = 0;
  logic [3:0] wbe = 0;
  logic [31:0] rd0, rd1, dbg0, dbg1;
  logic rv0, rv1, busy0, busy1;
  int total = 0, bad = 0;
  int depth [2] = '{1024, 1000};
  int mode [2] = '{0, 1};
  logic [31:0] mm [2][1024];
  bit mbusy [2];
  int left [2];
  typedef struct {
    logic we; logic [9:0] wa; logic [31:0] wd; logic [3:0] wbe;
    logic re; logic [9:0] ra; logic de; logic [9:0] da;
    logic erv; logic [31:0] e0, e1, d0, d1;
  } vec_t;
  vec_t tbl [20];
  always #5 clk = ~clk;
  mem_sync_bw #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .rd(rd0), .rvalid(rv0), .wa(wa), .wd(wd), .we(we), .wbe(wbe),
    .dbg_a(dbg_a), .dbg_e(dbg_e), .dbg_o(dbg0), .init_busy(busy0));
  mem_sync_bw #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .rd(rd1), .rvalid(rv1), .wa(wa), .wd(wd), .we(we), .wbe(wbe),
    .dbg_a(dbg_a), .dbg_e(dbg_e), .dbg_o(dbg1), .init_busy(busy1));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = nw[8*i +: 8];
    return m;
  endfunction
  task automatic cycle();
    logic [31:0] erd [2], edb [2], wnew;
    logic erv [2];
    for (int k = 0; k < 2; k++) begin
      erd[k] = 0; edb[k] = 0; erv[k] = 0;
      if (rst) begin
        mbusy[k] = 1; left[k] = depth[k];
      end else if (mbusy[k]) begin
        left[k]--;
        if (left[k] == 0) begin
          mbusy[k] = 0;
          for (int a = 0; a < 1024; a++) mm[k][a] = 0;
        end
      end else begin
        wnew = merge(mm[k][wa], wd, wbe);
        if (re) begin
          erv[k] = 1;
          if (ra < depth[k]) erd[k] = (mode[k] == 0 && we && wa == ra) ? wnew : mm[k][ra];
        end
        if (dbg_e && dbg_a < depth[k]) edb[k] = (mode[k] == 0 && we && wa == dbg_a) ? wnew : mm[k][dbg_a];
        if (we && wa < depth[k]) mm[k][wa] = wnew;
      end
    end
    @(posedge clk);
    #1;
    chk("rd0", rd0, erd[0]); chk("rd1", rd1, erd[1]);
    chk("rvalid0", rv0, erv[0]); chk("rvalid1", rv1, erv[1]);
    chk("dbg0", dbg0, edb[0]); chk("dbg1", dbg1, edb[1]);
    chk("busy0", busy0, mbusy[0]); chk("busy1", busy1, mbusy[1]);
  endtask
  function automatic logic [9:0] pick();
    if ($urandom_range(0, 9) < 7) return 10'($urandom_range(0, 15));
    return 10'($urandom_range(990, 1023));
  endfunction
  task automatic idle();
    re = 0; we = 0; dbg_e = 0; ra = 0; wa = 0; dbg_a = 0; wd = 0; wbe = 0;
  endtask
  task automatic rand_in();
    re = 1'($urandom); we = 1'($urandom); dbg_e = 1'($urandom);
    ra = pick(); wa = pick(); dbg_a = pick(); wd = $urandom; wbe = 4'($urandom);
  endtask
  task automatic rst_count();
    int c0, c1, n;
    rst = 1; rand_in(); cycle();
    rst = 0;
    c0 = int'(busy0); c1 = int'(busy1); n = 0;
    while ((busy0 || busy1) && n < 3000) begin
      if (busy1) rand_in(); else idle();
      cycle();
      c0 += int'(busy0); c1 += int'(busy1); n++;
    end
    chk("clear_len0", c0, 1024);
    chk("clear_len1", c1, 1000);
    idle();
  endtask
  initial begin
    tbl[0]  = '{1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 32'h11223344, 4'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 5, 0, 0, 1, 32'hAA22CC44, 32'hAA22CC44, 0, 0};
    tbl[3]  = '{1, 7, 32'hDEADBEEF, 4'hF, 1, 7, 1, 7, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 7, 1, 7, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1010, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 1010, 0, 0, 1, 32'h12345678, 0, 0, 0};
    tbl[8]  = '{1, 999, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 999, 1, 999, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[10] = '{1, 5, 32'h55667788, 4'h9, 1, 5, 1, 5, 1, 32'h5522CC88, 32'hAA22CC44, 32'h5522CC88, 32'hAA22CC44};
    for (int i = 0; i < 4; i++) begin
      tbl[11+i] = '{1, 10'(i), 32'h100 + i, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[15+i] = '{0, 0, 0, 0, 1, 10'(i), 0, 0, 1, 32'h100 + i, 32'h100 + i, 0, 0};
    end
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    idle();
    rst = 1;
    cycle();
    rst_count();
    foreach (tbl[i]) if (i < 3) begin
      we = 1; wa = (i == 0) ? 10'd0 : (i == 1) ? 10'd511 : 10'd1023; wd = 32'h5A5A0000 + i; wbe = 4'hF;
      cycle();
    end
    idle();
    rst_count();
    for (int i = 0; i < 3; i++) begin
      re = 1; ra = (i == 0) ? 10'd0 : (i == 1) ? 10'd511 : 10'd1023;
      cycle();
      chk($sformatf("clr_rd%0d", i), rd0, 0);
      chk($sformatf("clr_rv%0d", i), rv0, 1);
    end
    idle();
    for (int i = 0; i < 20; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; wbe = tbl[i].wbe;
      re = tbl[i].re; ra = tbl[i].ra; dbg_e = tbl[i].de; dbg_a = tbl[i].da;
      cycle();
      chk($sformatf("vec%0d_rv0", i), rv0, tbl[i].erv);
      chk($sformatf("vec%0d_rv1", i), rv1, tbl[i].erv);
      chk($sformatf("vec%0d_rd0", i), rd0, tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("vec%0d_dbg0", i), dbg0, tbl[i].d0);
      chk($sformatf("vec%0d_dbg1", i), dbg1, tbl[i].d1);
    end
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cycle();
    end
    idle();
    re = 1; ra = 3; rst = 1;
    cycle();
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    rst = 0;
    for (int i = 0; i < 300; i++) begin
      rand_in();
      cycle();
    end
    rst_count();
    for (int i = 0; i < 200; i++) begin
      rand_in();
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_sync_bw.md
# mem_sync_bw

Parametrised synchronous single-write, dual-read memory: the next-generation data and instruction store for the lab datapath. It adds the following:

- configurable width and depth;
- per-byte write enables;
- registered (1-cycle) read and debug ports with a valid strobe;
- selectable read-during-write mode;
- a hardware clear engine that zeroes the whole array after reset.

It sits between the CPU memory stage (read/write ports) and the board debug/display logic (debug port).

## Interface

- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width.
- DEPTH, 1024, number of words; 1 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0, read-during-write behaviour: 0 = write-first (new data returned), 1 = read-first (old data returned).

Ports:

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ra  in  ADDR_W  read address.
- re  in  1  read enable.
- rd  out  DATA_W  read data, valid when rvalid=1, else 0.
- rvalid  out  1  read data valid, 1 cycle after accepted re.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- we  in  1  write enable.
- wbe  in  DATA_W/8  byte-lane write enables; lane i = wd[8i+7:8i].
- dbg_a  in  ADDR_W  debug read address.
- dbg_e  in  1  debug read enable.
- dbg_o  out  DATA_W  debug read data, 1-cycle latency, 0 when not enabled.
- init_busy  out  1  high while the clear engine runs; all port requests are ignored.

## Operation

**Reset** (rst=1 at an edge):
- State goes to CLEAR and the clear counter to 0.
- rd=0, rvalid=0, dbg_o=0, init_busy=1.
- Array contents are not touched during the reset cycle itself.

**CLEAR:**
- Each cycle with rst=0 writes 0 to memory[cnt] and increments cnt.
- After the write of address DEPTH-1, the state goes to READY and init_busy falls on the same edge.
- Clearing takes exactly DEPTH cycles after rst falls.
- While in CLEAR: we is dropped, re/dbg_e are ignored, rvalid=0, rd=0, dbg_o=0.
- rst asserted mid-clear restarts from address 0.

**READY** (never left except by rst):
- Write: when we=1, each lane i with wbe[i]=1 takes wd lane i; other lanes keep their old value. we=1 with wbe=0 is a no-op.
- Read: re=1 at edge N gives rd = memory[ra] and rvalid=1 after edge N+1. re=0 gives rvalid=0 and rd=0 on the next cycle. Back-to-back reads sustain 1 word/cycle.
- Debug: dbg_e=1 gives dbg_o = memory[dbg_a] after the next edge, otherwise 0. There is no valid strobe. The debug port is independent of the read port and may target any address simultaneously.
- Read-during-write (same address, same edge, applies to both the read and debug ports):
  - RDW_MODE=0: returned word is the byte-merged new value (lanes with wbe=1 from wd, others old).
  - RDW_MODE=1: returned word is the pre-write value.
- Out-of-range address (>= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - writes are dropped;
  - reads return 0 with rvalid=1;
  - debug returns 0.
- rst in READY squashes any pending rvalid and read data on that edge, then re-runs CLEAR.

**Implementation notes:**
- Array is DEPTH x DATA_W.
- Clear counter is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W terminates without wrap.
- No combinational path from any input to any output.

## Timing

- Read latency: 1 cycle (address edge N, data and rvalid valid from edge N+1 to N+2).
- Debug latency: 1 cycle.
- Write takes effect at the edge; a read of the same address on the next edge sees new data in both modes.
- Clear time: DEPTH cycles after rst deasserts. First request accepted on the edge where init_busy is already 0.
- Priority at an edge: rst > CLEAR > port requests.

## Test plan

- **Reset/clear:** fill scratch values, pulse rst 1 cycle. Expect init_busy=1 for exactly DEPTH (1024) cycles. Then reads of addresses 0, 511, 1023 return 0x00000000 with rvalid=1. Requests issued during busy return rvalid=0, and no write lands.
- **Byte enables:** write 0xAABBCCDD full-word to address 5, then write 0x11223344 with wbe=4'b0101 to address 5. Read of 5 returns 0xAA22CC44 one cycle after re.
- **Read-during-write:** address 7 holds 0x0; same-edge we=1 (wd=0xDEADBEEF, wbe=4'hF) and re=1 to address 7. RDW_MODE=0 gives rd=0xDEADBEEF; RDW_MODE=1 gives rd=0x00000000. The next read gives 0xDEADBEEF in both. Repeat on the debug port.
- **Back-to-back and enables:** re=1 for addresses 0..3 on consecutive cycles. Expect rvalid high for 4 cycles with data in order. re=0 on the following cycle gives rvalid=0, rd=0. dbg_e=0 gives dbg_o=0.
- **Reset mid-operation:** assert rst while re=1 and 300 cycles into a clear. Expect rvalid=0 next cycle and the clear counter restarted at 0 (full DEPTH cycles to init_busy=0).
- **Out-of-range with DEPTH=1000, ADDR_W=10:** write 0x12345678 to address 1010, then read 1010 → rd=0 with rvalid=1. Clear completes in 1000 cycles. Address 999 is readable and writable.
